// File: rtl/bram_stream_reader_pkg.sv
// rtl/bram_stream_reader_pkg.sv - shared types and constants for the BRAM stream reader
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Cycles from a ram_en cycle until ram_dout carries that word.
    localparam int RAM_READ_LATENCY = 2;

endpackage

// File: rtl/stream_sync_fifo.sv
// rtl/stream_sync_fifo.sv - first-word-fall-through synchronous FIFO for the output stream
module stream_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                     clka,
    input  logic                     rstb,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer and occupancy update; a push into a full FIFO or a pop from an empty one is dropped.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clka) begin
        if (rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clka) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - reads a burst of BRAM words and streams them out with credit flow control
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter  int RAM_WIDTH  = 18,
    parameter  int RAM_DEPTH  = 1024,
    parameter  int FIFO_DEPTH = 4,
    localparam int AW         = $clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic                 rstb,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW:0]          length,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        ram_addr,
    output logic                 ram_en,
    output logic                 ram_regce,
    output logic                 ram_we,
    input  logic [RAM_WIDTH-1:0] ram_dout,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(RAM_DEPTH - 1);
    localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);

    state_t                       state_q, state_d;
    logic [AW-1:0]                addr_q, addr_d;
    logic [AW:0]                  issue_left_q, issue_left_d;
    logic [AW:0]                  xfer_left_q, xfer_left_d;
    logic [RAM_READ_LATENCY-1:0]  vpipe_q, vpipe_d;
    logic                         credit_ok;
    logic                         ram_en_c;
    logic                         pop;
    logic                         push;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [CW-1:0]                fifo_count;

    assign busy      = (state_q != IDLE) || (start && !rstb);
    assign done      = (state_q == FIN);
    assign ram_addr  = addr_q;
    assign ram_en    = ram_en_c;
    assign ram_regce = !rstb;
    assign ram_we    = 1'b0;
    assign m_valid   = !fifo_empty;
    assign pop       = m_valid && m_ready;
    assign push      = vpipe_q[RAM_READ_LATENCY-1] && !fifo_full;

    // Next-state logic: issue reads only while every word in flight or buffered has a FIFO slot.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        xfer_left_d  = xfer_left_q;
        credit_ok    = (int'(fifo_count) + $countones(vpipe_q)) < FIFO_DEPTH;
        ram_en_c     = (state_q == ISSUE) && credit_ok;
        vpipe_d      = {vpipe_q[RAM_READ_LATENCY-2:0], ram_en_c};
        if (pop) xfer_left_d = xfer_left_q - LEN_ONE;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d       = base_addr;
                    issue_left_d = length;
                    xfer_left_d  = length;
                    state_d      = (length == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (ram_en_c) begin
                    addr_d       = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
                    issue_left_d = issue_left_q - LEN_ONE;
                    if (issue_left_q == LEN_ONE) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && xfer_left_q == LEN_ONE) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, address, burst counters and the RAM latency valid pipe.
    always_ff @(posedge clka) begin
        if (rstb) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            xfer_left_q  <= '0;
            vpipe_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            xfer_left_q  <= xfer_left_d;
            vpipe_q      <= vpipe_d;
        end
    end

    stream_sync_fifo #(
        .WIDTH (RAM_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clka    (clka),
        .rstb    (rstb),
        .push    (push),
        .wr_data (ram_dout),
        .pop     (pop),
        .rd_data (m_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - self-checking bench for bram_stream_reader
module tb_bram_stream_reader;

    localparam int DEPTH = 1024;

    logic        clka;
    logic        rstb;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic [9:0]  ram_addr;
    logic        ram_en;
    logic        ram_regce;
    logic        ram_we;
    logic [17:0] ram_dout;
    logic [17:0] m_data;
    logic        m_valid;
    logic        m_ready;

    logic [17:0] ram_mem [DEPTH];
    logic [17:0] ram_lat;

    logic [17:0] words[$];
    int          en_addrs[$];
    int          en_cnt, done_cnt, first_valid_k, last_xfer_k, done_k, max_out, busy_cycles;
    logic        busy_after;
    int          tests_run, tests_failed;

    bram_stream_reader u_dut (
        .clka      (clka),
        .rstb      (rstb),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_en    (ram_en),
        .ram_regce (ram_regce),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Port-B RAM with an output register: data appears two cycles after the enable cycle.
    always @(posedge clka) begin
        if (ram_en) ram_lat <= ram_mem[ram_addr];
        if (ram_regce) ram_dout <= ram_lat;
    end

    // Runs one burst and records everything observed; called at #1 after a clock edge.
    task automatic do_burst(input logic [9:0] base, input logic [10:0] len, input int ready_pct, input bit inject);
        int k;
        int post;
        words.delete();
        en_addrs.delete();
        en_cnt = 0; done_cnt = 0; first_valid_k = -1; last_xfer_k = -1; done_k = -1;
        max_out = 0; busy_cycles = 0; busy_after = 1'b1;
        base_addr = base;
        length = len;
        start = 1'b1;
        #1;
        if (busy) busy_cycles++;
        @(posedge clka); #1;
        start = 1'b0;
        k = 0;
        post = 0;
        while (k < 3000 && post < 2) begin
            m_ready = (int'($urandom_range(99)) < ready_pct);
            start = inject && (k == 2);
            if (inject && k == 2) begin
                base_addr = base + 10'd100;
                length = 11'd5;
            end
            #1;
            if (busy) busy_cycles++;
            if (ram_en) begin
                en_addrs.push_back(int'(ram_addr));
                en_cnt++;
            end
            if (en_cnt - int'(words.size()) > max_out) max_out = en_cnt - int'(words.size());
            if (m_valid) begin
                if (first_valid_k < 0) first_valid_k = k;
                if (m_ready) begin
                    words.push_back(m_data);
                    last_xfer_k = k;
                end
            end
            if (done) begin
                done_cnt++;
                done_k = k;
            end
            if (done_k >= 0 && k == done_k + 1) busy_after = busy;
            if (done_cnt > 0) post++;
            @(posedge clka); #1;
            k++;
        end
        start = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstb = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = '0; length = '0;
        repeat (3) @(posedge clka);
        #1;
        tests_run++;
        if ({busy, done, m_valid, ram_en} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy/done/m_valid/ram_en=%b expected 0000", {busy, done, m_valid, ram_en});
        end
        tests_run++;
        if (ram_addr !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_ram_addr: got %0d expected 0", ram_addr);
        end
        tests_run++;
        if ({ram_regce, ram_we} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_regce_we: got %b expected 00", {ram_regce, ram_we});
        end
        rstb = 1'b0;
        #1;
        tests_run++;
        if (ram_regce !== 1'b1) begin
            tests_failed++;
            $display("FAIL regce_after_reset: got %b expected 1", ram_regce);
        end
        @(posedge clka); #1;
    endtask

    task automatic test_basic();
        int bad;
        do_burst(10'h010, 11'd8, 100, 1'b0);
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (i >= words.size() || words[i] !== ram_mem[(16 + i) % DEPTH]) bad++;
        tests_run++;
        if (bad != 0 || words.size() != 8) begin
            tests_failed++;
            $display("FAIL basic_data: %0d words, %0d wrong, expected 8 words 0 wrong", words.size(), bad);
        end
        tests_run++;
        if (first_valid_k != 3) begin
            tests_failed++;
            $display("FAIL basic_first_valid: got cycle %0d expected 3", first_valid_k);
        end
        tests_run++;
        if (last_xfer_k - first_valid_k != 7) begin
            tests_failed++;
            $display("FAIL basic_consecutive: span %0d expected 7", last_xfer_k - first_valid_k);
        end
        tests_run++;
        if (done_cnt != 1 || done_k != last_xfer_k + 1) begin
            tests_failed++;
            $display("FAIL basic_done: %0d pulses at %0d expected 1 at %0d", done_cnt, done_k, last_xfer_k + 1);
        end
        tests_run++;
        if (busy_cycles != done_k + 2 || busy_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_busy: %0d cycles after=%b expected %0d after=0", busy_cycles, busy_after, done_k + 2);
        end
        tests_run++;
        if (en_cnt != 8) begin
            tests_failed++;
            $display("FAIL basic_en_count: got %0d expected 8", en_cnt);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        do_burst(10'd300, 11'd16, 30, 1'b0);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (i >= words.size() || words[i] !== ram_mem[(300 + i) % DEPTH]) bad++;
        tests_run++;
        if (bad != 0 || words.size() != 16) begin
            tests_failed++;
            $display("FAIL bp_data: %0d words, %0d wrong, expected 16 words 0 wrong", words.size(), bad);
        end
        tests_run++;
        if (max_out > 4) begin
            tests_failed++;
            $display("FAIL bp_credit: outstanding %0d expected at most 4", max_out);
        end
        tests_run++;
        if (done_cnt != 1 || en_cnt != 16) begin
            tests_failed++;
            $display("FAIL bp_done_en: done %0d en %0d expected 1 and 16", done_cnt, en_cnt);
        end
    endtask

    task automatic test_wrap();
        int bad;
        int exp_addr[4];
        exp_addr = '{1022, 1023, 0, 1};
        do_burst(10'd1022, 11'd4, 60, 1'b0);
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (i >= en_addrs.size() || en_addrs[i] != exp_addr[i]) bad++;
        tests_run++;
        if (bad != 0 || en_addrs.size() != 4) begin
            tests_failed++;
            $display("FAIL wrap_addr: %0d reads, %0d wrong, expected 4 reads 0 wrong", en_addrs.size(), bad);
        end
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (i >= words.size() || words[i] !== ram_mem[exp_addr[i]]) bad++;
        tests_run++;
        if (bad != 0 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL wrap_data: %0d wrong, done %0d expected 0 wrong and 1 done", bad, done_cnt);
        end
    endtask

    task automatic test_zero_length();
        do_burst(10'd50, 11'd0, 100, 1'b0);
        tests_run++;
        if (en_cnt != 0 || first_valid_k != -1) begin
            tests_failed++;
            $display("FAIL zero_activity: en %0d first_valid %0d expected 0 and -1", en_cnt, first_valid_k);
        end
        tests_run++;
        if (done_cnt != 1 || done_k != 0) begin
            tests_failed++;
            $display("FAIL zero_done: %0d pulses at %0d expected 1 at 0", done_cnt, done_k);
        end
        tests_run++;
        if (busy_cycles != 2) begin
            tests_failed++;
            $display("FAIL zero_busy: got %0d cycles expected 2", busy_cycles);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        int k;
        int seen;
        int bad;
        base_addr = 10'd200; length = 11'd32; start = 1'b1; m_ready = 1'b1;
        @(posedge clka); #1;
        start = 1'b0;
        n = 0;
        k = 0;
        while (n < 5 && k < 200) begin
            if (m_valid && m_ready) n++;
            @(posedge clka); #1;
            k++;
        end
        tests_run++;
        if (n != 5) begin
            tests_failed++;
            $display("FAIL rst_mid_xfers: got %0d transfers expected 5", n);
        end
        rstb = 1'b1;
        #1;
        tests_run++;
        if (ram_regce !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_regce: got %b expected 0", ram_regce);
        end
        @(posedge clka); #1;
        rstb = 1'b0;
        tests_run++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_abort: m_valid=%b busy=%b expected 0 0", m_valid, busy);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_valid || done || ram_en) seen++;
            @(posedge clka); #1;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL rst_mid_quiet: %0d active cycles expected 0", seen);
        end
        do_burst(10'd500, 11'd2, 100, 1'b0);
        bad = 0;
        for (int i = 0; i < 2; i++)
            if (i >= words.size() || words[i] !== ram_mem[500 + i]) bad++;
        tests_run++;
        if (bad != 0 || words.size() != 2 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL rst_mid_recover: %0d words %0d wrong done %0d expected 2 0 1", words.size(), bad, done_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        int bad;
        do_burst(10'd700, 11'd12, 100, 1'b1);
        bad = 0;
        for (int i = 0; i < 12; i++)
            if (i >= words.size() || words[i] !== ram_mem[700 + i]) bad++;
        tests_run++;
        if (bad != 0 || words.size() != 12) begin
            tests_failed++;
            $display("FAIL busy_start_data: %0d words %0d wrong expected 12 0", words.size(), bad);
        end
        tests_run++;
        if (done_cnt != 1 || en_cnt != 12) begin
            tests_failed++;
            $display("FAIL busy_start_done: done %0d en %0d expected 1 and 12", done_cnt, en_cnt);
        end
    endtask

    task automatic test_random();
        int bad;
        int b;
        int len;
        for (int r = 0; r < 5; r++) begin
            b   = int'($urandom_range(1023));
            len = int'($urandom_range(40, 1));
            do_burst(10'(b), 11'(len), int'($urandom_range(100, 20)), 1'b0);
            bad = 0;
            for (int i = 0; i < len; i++) begin
                if (i >= words.size() || words[i] !== ram_mem[(b + i) % DEPTH]) bad++;
                if (i >= en_addrs.size() || en_addrs[i] != (b + i) % DEPTH) bad++;
            end
            tests_run++;
            if (bad != 0 || words.size() != len || done_cnt != 1 || max_out > 4) begin
                tests_failed++;
                $display("FAIL random_burst base=%0d len=%0d: %0d words %0d wrong done %0d out %0d", b, len, words.size(), bad, done_cnt, max_out);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = 18'($urandom);
        ram_lat = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_length();
        test_reset_mid_burst();
        test_start_while_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
